// File: rtl/decoder_scan_if.sv
// Handshake and decoder-drive bundle between a scan controller and the
// decoder_scan_sequencer.
interface decoder_scan_if #(
  parameter int DWELL_W = 8
) ();
  logic               start;
  logic               stop;
  logic [7:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic               continuous;
  logic [2:0]         sel;
  logic               en;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, mask, dwell, continuous,
    input  sel, en, busy, done
  );

  modport slave (
    input  start, stop, mask, dwell, continuous,
    output sel, en, busy, done
  );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Scans enabled decoder channels in ascending order with a programmable dwell
// and a one-cycle break-before-make gap between channels.
module decoder_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  decoder_scan_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  state_t             state, state_nxt;
  logic [7:0]         mask_r;
  logic [DWELL_W-1:0] dwell_r;
  logic               cont_r;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [2:0]         sel_nxt;
  logic               en_nxt, busy_nxt, done_nxt;
  logic               accept;
  logic               has_above;
  logic [2:0]         above_ch;
  logic [2:0]         next_ch;

  function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign accept = (state == IDLE) && bus.start && !bus.stop;

  // Next channel: lowest enabled channel above the current one, else wrap.
  always_comb begin
    has_above = 1'b0;
    above_ch  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_r[i] && (i > int'(bus.sel))) begin
        has_above = 1'b1;
        above_ch  = 3'(i);
      end
    end
    next_ch = has_above ? above_ch : lowest_set(mask_r);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && (bus.mask != 8'd0)) state_nxt = ON;
      ON: begin
        if (bus.stop)          state_nxt = IDLE;
        else if (cnt == '0)    state_nxt = (has_above || cont_r) ? GAP : IDLE;
      end
      GAP:     state_nxt = bus.stop ? IDLE : ON;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath next values; everything leaves the block through registers.
  always_comb begin
    sel_nxt  = bus.sel;
    en_nxt   = 1'b0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    cnt_nxt  = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.mask == 8'd0) begin
            done_nxt = 1'b1;
          end else begin
            sel_nxt  = lowest_set(bus.mask);
            en_nxt   = 1'b1;
            busy_nxt = 1'b1;
            cnt_nxt  = eff_dwell(bus.dwell) - DWELL_W'(1);
          end
        end
      end
      ON: begin
        if (!bus.stop) begin
          if (cnt != '0) begin
            en_nxt   = 1'b1;
            busy_nxt = 1'b1;
            cnt_nxt  = cnt - DWELL_W'(1);
          end else if (has_above || cont_r) begin
            busy_nxt = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      GAP: begin
        if (!bus.stop) begin
          sel_nxt  = next_ch;
          en_nxt   = 1'b1;
          busy_nxt = 1'b1;
          cnt_nxt  = dwell_r - DWELL_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sel  <= 3'd0;
      bus.en   <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      cnt      <= '0;
    end else begin
      bus.sel  <= sel_nxt;
      bus.en   <= en_nxt;
      bus.busy <= busy_nxt;
      bus.done <= done_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Scan parameters are frozen at an accepted start.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mask_r  <= bus.mask;
      dwell_r <= eff_dwell(bus.dwell);
      cont_r  <= bus.continuous;
    end
  end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed scoreboard bench for decoder_scan_sequencer: expected per-cycle
// {sel,en,busy,done} vectors are queued with the stimulus and popped each cycle.
module tb_decoder_scan_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decoder_scan_if #(.DWELL_W(8)) bus ();

  decoder_scan_sequencer #(.DWELL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [5:0] exp_q[$];
  string      tag;
  int         checks = 0;
  int         errors = 0;

  task automatic push(input logic [2:0] s, input logic e, input logic b, input logic d);
    exp_q.push_back({s, e, b, d});
  endtask

  // Expected trace of a scan derived from the channel list and dwell timing.
  task automatic push_scan(input logic [7:0] m, input int d, input bit cont, input int periods);
    int ch[$];
    int de;
    int passes;
    de     = (d == 0) ? 1 : d;
    passes = cont ? periods : 1;
    for (int i = 0; i < 8; i++) if (m[i]) ch.push_back(i);
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < ch.size(); k++) begin
        for (int j = 0; j < de; j++) push(3'(ch[k]), 1'b1, 1'b1, 1'b0);
        if (cont || (k != ch.size() - 1)) push(3'(ch[k]), 1'b0, 1'b1, 1'b0);
      end
    end
    if (!cont) push(3'(ch[ch.size()-1]), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic tick();
    logic [5:0] obs;
    logic [5:0] exp_v;
    @(posedge clk);
    #1;
    obs = {bus.sel, bus.en, bus.busy, bus.done};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %b with no expected entry", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: {sel,en,busy,done} observed %b expected %b", tag, obs, exp_v);
      end
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) tick();
  endtask

  task automatic set_in(input logic s, input logic p, input logic [7:0] m,
                        input logic [7:0] d, input logic c);
    bus.start = s; bus.stop = p; bus.mask = m; bus.dwell = d; bus.continuous = c;
  endtask

  initial begin
    set_in(1'b0, 1'b0, 8'h00, 8'd0, 1'b0);

    tag = "reset";
    push(3'd0, 1'b0, 1'b0, 1'b0); tick();
    push(3'd0, 1'b0, 1'b0, 1'b0); tick();
    rst = 1'b0;
    push(3'd0, 1'b0, 1'b0, 1'b0); tick();

    tag = "full_pass";
    set_in(1'b1, 1'b0, 8'hFF, 8'd2, 1'b0);
    push_scan(8'hFF, 2, 1'b0, 1);
    tick();
    bus.start = 1'b0;
    drain();
    tag = "full_pass_idle";
    push(3'd7, 1'b0, 1'b0, 1'b0); tick();

    tag = "sparse_dwell0";
    set_in(1'b1, 1'b0, 8'b1010_0100, 8'd0, 1'b0);
    push_scan(8'b1010_0100, 0, 1'b0, 1);
    tick();
    bus.start = 1'b0;
    drain();

    tag = "empty_mask";
    set_in(1'b1, 1'b0, 8'h00, 8'd4, 1'b0);
    push(3'd7, 1'b0, 1'b0, 1'b1);
    tick();
    bus.start = 1'b0;
    push(3'd7, 1'b0, 1'b0, 1'b0); tick();
    push(3'd7, 1'b0, 1'b0, 1'b0); tick();

    tag = "continuous";
    set_in(1'b1, 1'b0, 8'h81, 8'd3, 1'b1);
    push_scan(8'h81, 3, 1'b1, 3);
    for (int j = 0; j < 3; j++) push(3'd0, 1'b1, 1'b1, 1'b0);
    push(3'd0, 1'b0, 1'b1, 1'b0);
    push(3'd7, 1'b1, 1'b1, 1'b0);
    push(3'd7, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 8'h0F, 8'd7, 1'b0);
    drain();
    tag = "continuous_stop";
    bus.stop = 1'b1;
    push(3'd7, 1'b0, 1'b0, 1'b0); tick();
    bus.stop = 1'b0;
    push(3'd7, 1'b0, 1'b0, 1'b0); tick();
    push(3'd7, 1'b0, 1'b0, 1'b0); tick();

    tag = "start_while_busy";
    set_in(1'b1, 1'b0, 8'h06, 8'd1, 1'b0);
    push_scan(8'h06, 1, 1'b0, 1);
    tick();
    set_in(1'b1, 1'b0, 8'hFF, 8'd9, 1'b1);
    tick(); tick(); tick();
    tag = "start_on_done";
    set_in(1'b1, 1'b0, 8'h10, 8'd2, 1'b0);
    push_scan(8'h10, 2, 1'b0, 1);
    tick();
    bus.start = 1'b0;
    drain();

    tag = "start_and_stop_idle";
    set_in(1'b1, 1'b1, 8'hFF, 8'd2, 1'b0);
    push(3'd4, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b0, 8'hFF, 8'd2, 1'b0);
    push(3'd4, 1'b0, 1'b0, 1'b0); tick();

    tag = "reset_mid_dwell";
    set_in(1'b1, 1'b0, 8'h08, 8'd5, 1'b0);
    push(3'd3, 1'b1, 1'b1, 1'b0); tick();
    bus.start = 1'b0;
    push(3'd3, 1'b1, 1'b1, 1'b0); tick();
    rst = 1'b1;
    bus.start = 1'b1;
    push(3'd0, 1'b0, 1'b0, 1'b0); tick();
    push(3'd0, 1'b0, 1'b0, 1'b0); tick();
    rst = 1'b0;
    bus.start = 1'b0;
    push(3'd0, 1'b0, 1'b0, 1'b0); tick();

    tag = "after_reset";
    set_in(1'b1, 1'b0, 8'h30, 8'd1, 1'b0);
    push_scan(8'h30, 1, 1'b0, 1);
    tick();
    bus.start = 1'b0;
    drain();
    push(3'd5, 1'b0, 1'b0, 1'b0); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_scan_sequencer.md
# decoder_scan_sequencer

Upstream driver for the 3-to-8 decoder.
- Scans the enabled channels in ascending order.
- Presents each channel's 3-bit select and its enable for a programmable dwell time.
- Inserts a one-cycle blanking gap between channels so that only one decoder output is active at a time (break-before-make).
- Supports single-pass and continuous scans with a start/stop/done handshake.
- Its `sel`/`en` outputs connect directly to the decoder's `in`/`en` inputs.

## Interface
- `DWELL_W`, default 8: width of the dwell-count input and the internal dwell counter.

Ports (all outputs are registered):
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a scan pass; accepted only in IDLE.
- `stop`  in  1  aborts an active scan.
- `mask`  in  8  channel-enable mask; bit i enables channel i. Sampled on an accepted start.
- `dwell`  in  `DWELL_W`  number of cycles `en` stays high per channel. Sampled on an accepted start; 0 is treated as 1.
- `continuous`  in  1  sampled on an accepted start; 1 repeats passes until stop.
- `sel`  out  3  channel index to the decoder.
- `en`  out  1  decoder enable.
- `busy`  out  1  high while a scan is active (ON or GAP state).
- `done`  out  1  one-cycle pulse on normal completion of a single pass.

## Operation
- Internal registers: `mask_r`, `dwell_r` (effective value, minimum 1), `cont_r`, state, and dwell counter `cnt`.
- States: IDLE, ON, GAP.
- IDLE: `en`=0, `busy`=0, `sel` holds its last value.
  - start with `mask`=0: capture the inputs, stay in IDLE, pulse `done` on the next cycle.
  - start with `mask`≠0: go to ON. `sel` = lowest set bit of `mask`, `en`=1, `busy`=1, `cnt` = `dwell_eff`−1.
- ON: `en`=1; `cnt` decrements each cycle. When `cnt`=0:
  - A higher set bit exists in `mask_r`: go to GAP. `en`=0.
  - No higher bit and `cont_r`=1: go to GAP. `en`=0; the next channel wraps to the lowest set bit.
  - No higher bit and `cont_r`=0: go to IDLE. `en`=0, `busy`=0, `done`=1 for one cycle.
- GAP: exactly one cycle with `en`=0, `busy`=1. Then go to ON with `sel` = next channel, `en`=1, `cnt` reloaded.
- The next channel is found combinationally: the lowest set bit of `mask_r` above the current `sel`, else the lowest set bit overall.
- stop in ON or GAP: at the next edge go to IDLE with `en`=0 and `busy`=0; `done` is not asserted.
- Priorities:
  - stop has priority over the completion/advance decision.
  - start while busy is ignored.
  - start and stop together in IDLE: start is ignored.
- `mask`, `dwell` and `continuous` changes after acceptance have no effect until the next accepted start.
- Invariant: `sel` never changes while `en`=1. `sel` updates only on edges where `en` goes 0→1.

## Timing
- Reset values: `sel`=0, `en`=0, `busy`=0, `done`=0, state IDLE, `cnt`=0. Reset mid-scan returns all outputs to these values at the next edge.
- Latency: start sampled at edge N gives `en`=1 and `busy`=1 in the cycle after edge N.
- Per channel: `en` is high for exactly `dwell_eff` cycles, followed by 1 GAP cycle. The last channel of a single pass has no GAP.
- Single-pass busy duration: K·`dwell_eff` + (K−1) cycles, where K = popcount(`mask_r`).
- `done` is asserted in the first cycle after the last ON cycle, concurrent with `busy`=0. A new start is accepted in that same cycle.
- Continuous period: K·(`dwell_eff`+1) cycles.
- With K=1 and `continuous`=1, the same channel repeats with a 1-cycle gap: `en` pattern is `dwell_eff` high, 1 low.
- stop sampled at edge M gives `en`=0 and `busy`=0 in the cycle after edge M.

## Test plan
- Single full pass. `mask`=8'hFF, `dwell`=2, `continuous`=0.
  - Required: `sel` steps 0..7, each with `en` high 2 cycles and a 1-cycle gap; `busy` high 23 cycles; one `done` pulse immediately after; `sel` stays 7.
- Sparse mask with zero dwell. `mask`=8'b1010_0100, `dwell`=0.
  - Required: channels 2, 5, 7, each with `en` high 1 cycle; 2 gap cycles; `busy` high 5 cycles; then `done`.
- Empty mask. `mask`=0, start.
  - Required: `done` pulses the cycle after start; `en` and `busy` never high; `sel` unchanged.
- Continuous scan with stop. `mask`=8'h81, `dwell`=3, `continuous`=1. Run 3 periods, then assert stop during the 2nd dwell cycle of channel 7.
  - Required: period is 8 cycles with sequence 0,7,0,7…; `en`/`busy` go low the next cycle; no `done` pulse.
- Handshake robustness.
  - start during busy: ignored.
  - `mask`/`dwell` changed mid-pass: do not alter the pass.
  - start coincident with `done`: accepted; the new pass begins the next cycle.
  - start and stop together in IDLE: no scan starts.
- Reset. Assert `rst` mid-dwell.
  - Required: `sel`=0, `en`=0, `busy`=0, `done`=0 next cycle.
  - start asserted with `rst` high: ignored.
  - After reset release, a fresh start scans normally.
